pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Sequential next-PC controller in the PRE_IF stage. It arbitrates redirect requests from the exception/ERET/refetch path, the EXE branch/JR unit and the ID immediate-jump decoder, and owns the architectural fetch PC register. A redirect that arrives while fetch is stalled is held in a one-entry pending buffer, so no redirect is ever lost. The PC-select encoding is exported for the IF mux and for debug.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset
- EXC_VECTOR, 32'hBFC0_0380, general exception entry

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- fetch_stall  in  1  1 = IF cannot accept a new PC this cycle
- ex_entry_sel  in  3  IsNone/IsEret/IsException/IsRefetch, shared package codes
- cp0_epc  in  32  ERET target
- mem_pc  in  32  refetch target
- br_taken  in  1  EXE branch resolved taken
- br_is_jr  in  1  taken branch is JR/JALR
- br_target  in  32  branch or register target
- imm_jump  in  1  ID immediate jump (J/JAL)
- jump_target  in  32  immediate-jump target
- pc  out  32  current fetch PC
- pc_sel  out  3  source of current pc: PC4=000, IMMJ=001, EPC=010, EXC=011, BR=100, JR=101, MEMPC=110
- redirect_pending  out  1  redirect held in buffer
- flush_if  out  1  one-cycle pulse when the PC is loaded from any non-PC4 source

## Operation
- Request priority, highest first: Exception > Eret > Refetch > branch/JR > immediate jump > PC+4.
- Unknown ex_entry_sel codes (not one of the four) are treated as IsNone, with an assertion in simulation.
- FSM states:
  - RUN: no pending redirect.
  - HOLD: pending target and pending source valid.
- RUN:
  - If !fetch_stall, pc <= winner target (or pc+4), and pc_sel <= winner code.
  - If fetch_stall and a redirect wins, capture target and code into the buffer and go to HOLD. pc is unchanged.
  - If fetch_stall and there is no redirect, hold pc.
- HOLD:
  - A new exception-class request (Exception/Eret/Refetch) always overwrites the buffer.
  - A new branch/jump request overwrites only a pending immediate jump (IMMJ). Otherwise it is dropped, because it is younger than a pending exception-class redirect.
  - When fetch_stall is low: load pc from the buffer, or from a higher-priority same-cycle request if one exists. Then return to RUN.
- Same-cycle exception and branch: the exception wins and the branch is discarded.
- pc+4 uses 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 0.
- flush_if is asserted in the cycle after pc is loaded from a non-PC4 source, aligned with the new pc.
- Reset state, asynchronous and immediate:
  - pc = RESET_PC
  - pc_sel = 000
  - redirect_pending = 0
  - flush_if = 0
  - FSM = RUN
- A reset asserted mid-HOLD discards the buffer.

## Timing
- Redirect sampled in cycle N with fetch_stall=0 → new pc visible in N+1. Latency is one cycle.
- Redirect arriving during a stall → pc changes in the cycle after the first cycle with fetch_stall=0.
- The buffer holds for any stall length.
- redirect_pending rises in the cycle after capture and falls in the same cycle the new pc appears.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared CPU package contains:
  - ex_entry_sel codes (IsNone/IsEret/IsException/IsRefetch)
  - PCSel_* localparams (3-bit)
  - RESET_PC and EXC_VECTOR defaults
  - FSM enum (RUN/HOLD)
- One natural sub-module: redirect_prio_arb. It is a combinational priority encoder that outputs winner valid, 3-bit code and 32-bit target.
- The parent holds the pc register, the pending buffer and the FSM.

## Test plan
- Reset, then 3 free-run cycles → pc = BFC00000, BFC00004, BFC00008, BFC0000C with pc_sel = 000 throughout.
- br_taken with br_target=80001000 and no stall → next cycle pc=80001000, pc_sel=100, flush_if=1. With br_is_jr=1 instead → pc_sel=101.
- fetch_stall held 4 cycles while imm_jump with target 80002000 is pulsed for 1 cycle → redirect_pending=1 and pc unchanged during the stall. After release: pc=80002000, pc_sel=001, pending=0.
- During HOLD on a jump, ex_entry_sel=IsException arrives → after release pc=BFC00380, pc_sel=011.
- During HOLD on an Eret (cp0_epc=80000040), br_taken arrives → branch dropped; after release pc=80000040, pc_sel=010.
- Same cycle IsRefetch (mem_pc=80000100) and br_taken → pc=80000100, pc_sel=110. Separately, resetn deasserted during HOLD → pc=BFC00000 immediately and pending=0.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared PRE_IF definitions: exception-entry codes, PC-select codes,
// reset/exception vectors and the redirect FSM state type.
package pc_redirect_ctrl_pkg;

    // Exception-entry request codes driven by the exception unit
    localparam logic [2:0] IsNone      = 3'd0;
    localparam logic [2:0] IsEret      = 3'd1;
    localparam logic [2:0] IsException = 3'd2;
    localparam logic [2:0] IsRefetch   = 3'd3;

    // Source of the fetch PC, exported to the IF mux and debug
    localparam logic [2:0] PCSel_PC4   = 3'b000;
    localparam logic [2:0] PCSel_IMMJ  = 3'b001;
    localparam logic [2:0] PCSel_EPC   = 3'b010;
    localparam logic [2:0] PCSel_EXC   = 3'b011;
    localparam logic [2:0] PCSel_BR    = 3'b100;
    localparam logic [2:0] PCSel_JR    = 3'b101;
    localparam logic [2:0] PCSel_MEMPC = 3'b110;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } redir_state_e;

    // Exception-class redirects are older than any branch/jump in flight
    function automatic logic is_exc_class(input logic [2:0] sel);
        return (sel == PCSel_EPC) || (sel == PCSel_EXC) || (sel == PCSel_MEMPC);
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_chk.sv
// Simulation-only protocol checks for the redirect controller inputs.
module pc_redirect_ctrl_chk
    import pc_redirect_ctrl_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    input logic [2:0] ex_entry_sel
);

    // The exception unit must only ever drive one of the four known codes
    a_ex_entry_sel_known: assert property (@(posedge clk) disable iff (!resetn)
        (ex_entry_sel == IsNone) || (ex_entry_sel == IsEret) ||
        (ex_entry_sel == IsException) || (ex_entry_sel == IsRefetch));

endmodule

// File: rtl/pc_redirect_ctrl_prio_arb.sv
// Combinational priority encoder over all redirect sources:
// Exception > Eret > Refetch > branch/JR > immediate jump.
module redirect_prio_arb
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [2:0]  ex_entry_sel,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] mem_pc,
    input  logic        br_taken,
    input  logic        br_is_jr,
    input  logic [31:0] br_target,
    input  logic        imm_jump,
    input  logic [31:0] jump_target,
    output logic        win_valid,
    output logic [2:0]  win_code,
    output logic [31:0] win_target
);

    logic        exc_valid_s;
    logic [2:0]  exc_code_s;
    logic [31:0] exc_target_s;

    // Decode the exception-entry code; unrecognised codes behave as IsNone
    always_comb begin
        exc_valid_s  = 1'b0;
        exc_code_s   = PCSel_PC4;
        exc_target_s = 32'h0000_0000;
        case (ex_entry_sel)
            IsException: begin
                exc_valid_s  = 1'b1;
                exc_code_s   = PCSel_EXC;
                exc_target_s = EXC_VECTOR;
            end
            IsEret: begin
                exc_valid_s  = 1'b1;
                exc_code_s   = PCSel_EPC;
                exc_target_s = cp0_epc;
            end
            IsRefetch: begin
                exc_valid_s  = 1'b1;
                exc_code_s   = PCSel_MEMPC;
                exc_target_s = mem_pc;
            end
            default: begin
                exc_valid_s  = 1'b0;
                exc_code_s   = PCSel_PC4;
                exc_target_s = 32'h0000_0000;
            end
        endcase
    end

    // Pick the highest-priority active request
    always_comb begin
        win_valid  = 1'b0;
        win_code   = PCSel_PC4;
        win_target = 32'h0000_0000;
        if (exc_valid_s) begin
            win_valid  = 1'b1;
            win_code   = exc_code_s;
            win_target = exc_target_s;
        end else if (br_taken) begin
            win_valid  = 1'b1;
            win_code   = br_is_jr ? PCSel_JR : PCSel_BR;
            win_target = br_target;
        end else if (imm_jump) begin
            win_valid  = 1'b1;
            win_code   = PCSel_IMMJ;
            win_target = jump_target;
        end else begin
            win_valid  = 1'b0;
            win_code   = PCSel_PC4;
            win_target = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC controller: owns the fetch PC, arbitrates redirects and keeps a
// one-entry pending buffer so a redirect seen during a fetch stall survives.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_stall,
    input  logic [2:0]  ex_entry_sel,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] mem_pc,
    input  logic        br_taken,
    input  logic        br_is_jr,
    input  logic [31:0] br_target,
    input  logic        imm_jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [2:0]  pc_sel,
    output logic        redirect_pending,
    output logic        flush_if
);

    redir_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [2:0]   pc_sel_q, pc_sel_d;
    logic         pending_q, pending_d;
    logic         flush_q, flush_d;
    logic [31:0]  buf_tgt_q, buf_tgt_d;
    logic [2:0]   buf_code_q, buf_code_d;

    logic         win_valid_s;
    logic [2:0]   win_code_s;
    logic [31:0]  win_target_s;
    logic         overwrite_s;
    logic [31:0]  eff_tgt_s;
    logic [2:0]   eff_code_s;

    redirect_prio_arb #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
        .ex_entry_sel (ex_entry_sel),
        .cp0_epc      (cp0_epc),
        .mem_pc       (mem_pc),
        .br_taken     (br_taken),
        .br_is_jr     (br_is_jr),
        .br_target    (br_target),
        .imm_jump     (imm_jump),
        .jump_target  (jump_target),
        .win_valid    (win_valid_s),
        .win_code     (win_code_s),
        .win_target   (win_target_s)
    );

    pc_redirect_ctrl_chk u_chk (
        .clk          (clk),
        .resetn       (resetn),
        .ex_entry_sel (ex_entry_sel)
    );

    // Decide whether a new request replaces the buffered redirect: exception
    // class always does, branches/jumps only replace a pending immediate jump
    always_comb begin
        overwrite_s = win_valid_s &&
                      (is_exc_class(win_code_s) || (buf_code_q == PCSel_IMMJ));
        if (overwrite_s) begin
            eff_tgt_s  = win_target_s;
            eff_code_s = win_code_s;
        end else begin
            eff_tgt_s  = buf_tgt_q;
            eff_code_s = buf_code_q;
        end
    end

    // Next-state and next-PC logic for the RUN/HOLD redirect FSM
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_sel_d   = pc_sel_q;
        pending_d  = pending_q;
        flush_d    = 1'b0;
        buf_tgt_d  = buf_tgt_q;
        buf_code_d = buf_code_q;
        case (state_q)
            RUN: begin
                if (!fetch_stall) begin
                    if (win_valid_s) begin
                        pc_d     = win_target_s;
                        pc_sel_d = win_code_s;
                        flush_d  = 1'b1;
                    end else begin
                        pc_d     = pc_q + 32'd4;
                        pc_sel_d = PCSel_PC4;
                    end
                end else if (win_valid_s) begin
                    buf_tgt_d  = win_target_s;
                    buf_code_d = win_code_s;
                    pending_d  = 1'b1;
                    state_d    = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (!fetch_stall) begin
                    pc_d      = eff_tgt_s;
                    pc_sel_d  = eff_code_s;
                    flush_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = RUN;
                end else begin
                    buf_tgt_d  = eff_tgt_s;
                    buf_code_d = eff_code_s;
                end
            end
            default: begin
                pending_d = 1'b0;
                state_d   = RUN;
            end
        endcase
    end

    // State, PC and buffer registers; reset discards any pending redirect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pc_sel_q   <= PCSel_PC4;
            pending_q  <= 1'b0;
            flush_q    <= 1'b0;
            buf_tgt_q  <= 32'h0000_0000;
            buf_code_q <= PCSel_PC4;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_sel_q   <= pc_sel_d;
            pending_q  <= pending_d;
            flush_q    <= flush_d;
            buf_tgt_q  <= buf_tgt_d;
            buf_code_q <= buf_code_d;
        end
    end

    assign pc               = pc_q;
    assign pc_sel           = pc_sel_q;
    assign redirect_pending = pending_q;
    assign flush_if         = flush_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a request-level reference model
// compared on every falling clock edge, plus literal spot checks.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_stall;
    logic [2:0]  ex_entry_sel;
    logic [31:0] cp0_epc, mem_pc, br_target, jump_target;
    logic        br_taken, br_is_jr, imm_jump;
    logic [31:0] pc;
    logic [2:0]  pc_sel;
    logic        redirect_pending, flush_if;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .fetch_stall      (fetch_stall),
        .ex_entry_sel     (ex_entry_sel),
        .cp0_epc          (cp0_epc),
        .mem_pc           (mem_pc),
        .br_taken         (br_taken),
        .br_is_jr         (br_is_jr),
        .br_target        (br_target),
        .imm_jump         (imm_jump),
        .jump_target      (jump_target),
        .pc               (pc),
        .pc_sel           (pc_sel),
        .redirect_pending (redirect_pending),
        .flush_if         (flush_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A request is described by (valid, source code, target).
    typedef struct packed {
        logic        valid;
        logic [2:0]  code;
        logic [31:0] tgt;
    } req_t;

    logic [31:0] m_pc;
    logic [2:0]  m_sel;
    logic        m_pend, m_flush;
    req_t        m_held;

    // Collect every active request in priority order and take the first one.
    function automatic req_t pick_request();
        req_t list [6];
        list[0] = '{ex_entry_sel == IsException, PCSel_EXC,   32'hBFC0_0380};
        list[1] = '{ex_entry_sel == IsEret,      PCSel_EPC,   cp0_epc};
        list[2] = '{ex_entry_sel == IsRefetch,   PCSel_MEMPC, mem_pc};
        list[3] = '{br_taken && br_is_jr,        PCSel_JR,    br_target};
        list[4] = '{br_taken && !br_is_jr,       PCSel_BR,    br_target};
        list[5] = '{imm_jump,                    PCSel_IMMJ,  jump_target};
        for (int i = 0; i < 6; i++) if (list[i].valid) return list[i];
        return '{1'b0, PCSel_PC4, 32'h0};
    endfunction

    function automatic bit older_class(input logic [2:0] c);
        return c == PCSel_EXC || c == PCSel_EPC || c == PCSel_MEMPC;
    endfunction

    always @(posedge clk or negedge resetn) begin
        req_t r;
        if (!resetn) begin
            m_pc = 32'hBFC0_0000; m_sel = 3'b000; m_pend = 1'b0; m_flush = 1'b0;
            m_held = '{1'b0, 3'b000, 32'h0};
        end else begin
            r = pick_request();
            m_flush = 1'b0;
            if (m_pend) begin
                if (r.valid && (older_class(r.code) || m_held.code == PCSel_IMMJ))
                    m_held = r;
                if (!fetch_stall) begin
                    m_pc = m_held.tgt; m_sel = m_held.code; m_flush = 1'b1; m_pend = 1'b0;
                end
            end else if (!fetch_stall) begin
                if (r.valid) begin
                    m_pc = r.tgt; m_sel = r.code; m_flush = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd4; m_sel = 3'b000;
                end
            end else if (r.valid) begin
                m_held = r; m_pend = 1'b1;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("model_pc", pc, m_pc);
        chk("model_pc_sel", {29'd0, pc_sel}, {29'd0, m_sel});
        chk("model_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
        chk("model_flush", {31'd0, flush_if}, {31'd0, m_flush});
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_stall = 1'b0; ex_entry_sel = IsNone; br_taken = 1'b0;
        br_is_jr = 1'b0; imm_jump = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_pc;
        resetn = 1'b0;
        idle();
        cp0_epc = 32'h0; mem_pc = 32'h0; br_target = 32'h0; jump_target = 32'h0;
        cyc(); cyc();
        chk("reset_pc", pc, 32'hBFC0_0000);
        chk("reset_sel", {29'd0, pc_sel}, 32'd0);
        chk("reset_pend", {31'd0, redirect_pending}, 32'd0);
        chk("reset_flush", {31'd0, flush_if}, 32'd0);
        resetn = 1'b1;
        cyc(); chk("run_pc1", pc, 32'hBFC0_0004);
        cyc(); chk("run_pc2", pc, 32'hBFC0_0008);
        cyc(); chk("run_pc3", pc, 32'hBFC0_000C);
        chk("run_sel", {29'd0, pc_sel}, 32'd0);

        // Taken branch, then JR
        br_taken = 1'b1; br_target = 32'h8000_1000;
        cyc(); idle();
        chk("br_pc", pc, 32'h8000_1000);
        chk("br_sel", {29'd0, pc_sel}, 32'd4);
        chk("br_flush", {31'd0, flush_if}, 32'd1);
        cyc(); chk("br_flush_drop", {31'd0, flush_if}, 32'd0);
        br_taken = 1'b1; br_is_jr = 1'b1;
        cyc(); idle();
        chk("jr_sel", {29'd0, pc_sel}, 32'd5);

        // Immediate jump during a 4-cycle stall
        held_pc = pc;
        fetch_stall = 1'b1; imm_jump = 1'b1; jump_target = 32'h8000_2000;
        cyc(); imm_jump = 1'b0;
        chk("stall_pend", {31'd0, redirect_pending}, 32'd1);
        chk("stall_pc", pc, held_pc);
        cyc(); cyc(); cyc();
        chk("stall_pc_long", pc, held_pc);
        fetch_stall = 1'b0;
        cyc();
        chk("immj_pc", pc, 32'h8000_2000);
        chk("immj_sel", {29'd0, pc_sel}, 32'd1);
        chk("immj_pend", {31'd0, redirect_pending}, 32'd0);

        // Exception overwrites a pending jump
        fetch_stall = 1'b1; imm_jump = 1'b1;
        cyc(); imm_jump = 1'b0; ex_entry_sel = IsException;
        cyc(); ex_entry_sel = IsNone;
        cyc(); fetch_stall = 1'b0;
        cyc();
        chk("exc_pc", pc, 32'hBFC0_0380);
        chk("exc_sel", {29'd0, pc_sel}, 32'd3);

        // Branch dropped behind pending Eret
        fetch_stall = 1'b1; ex_entry_sel = IsEret; cp0_epc = 32'h8000_0040;
        cyc(); ex_entry_sel = IsNone; br_taken = 1'b1; br_target = 32'h8000_5000;
        cyc(); br_taken = 1'b0; fetch_stall = 1'b0;
        cyc();
        chk("eret_pc", pc, 32'h8000_0040);
        chk("eret_sel", {29'd0, pc_sel}, 32'd2);

        // Branch replaces pending jump; jump at release dropped behind branch
        fetch_stall = 1'b1; imm_jump = 1'b1; jump_target = 32'h8000_6000;
        cyc(); imm_jump = 1'b0; br_taken = 1'b1; br_target = 32'h8000_7000;
        cyc(); br_taken = 1'b0; fetch_stall = 1'b0; imm_jump = 1'b1;
        cyc(); idle();
        chk("br_over_immj_pc", pc, 32'h8000_7000);
        chk("br_over_immj_sel", {29'd0, pc_sel}, 32'd4);

        // Same-cycle refetch and branch
        ex_entry_sel = IsRefetch; mem_pc = 32'h8000_0100; br_taken = 1'b1;
        cyc(); idle();
        chk("refetch_pc", pc, 32'h8000_0100);
        chk("refetch_sel", {29'd0, pc_sel}, 32'd6);

        // Wrap-around of pc+4
        imm_jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        cyc(); idle();
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_post", pc, 32'h0000_0000);

        // Reset during HOLD discards the buffer
        fetch_stall = 1'b1; imm_jump = 1'b1; jump_target = 32'h8000_3000;
        cyc(); imm_jump = 1'b0;
        chk("hold_before_rst", {31'd0, redirect_pending}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_hold_pc", pc, 32'hBFC0_0000);
        chk("rst_hold_pend", {31'd0, redirect_pending}, 32'd0);
        fetch_stall = 1'b0;
        cyc(); resetn = 1'b1;
        cyc();
        chk("post_rst_pc", pc, 32'hBFC0_0004);
        chk("post_rst_sel", {29'd0, pc_sel}, 32'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
